// File: rtl/dkong3_vmix_pkg.sv
// dkong3_vmix_pkg: shared types for the video mixer.
// Fade states, palette lane codes, fade scaling helper.
package dkong3_vmix_pkg;

  localparam int FADE_W = 4;
  localparam logic [FADE_W-1:0] FADE_MAX = 4'hF;
  localparam logic [FADE_W-1:0] FADE_MIN = 4'h0;

  localparam logic [1:0] LANE_R = 2'd0;
  localparam logic [1:0] LANE_G = 2'd1;
  localparam logic [1:0] LANE_B = 2'd2;

  typedef enum logic [1:0] {
    FADE_IDLE,
    FADE_WAIT,
    FADE_STEP
  } fade_state_t;

  // c*(l+1)/16, so level 15 is unity gain
  function automatic logic [7:0] fade_scale(
    input logic [7:0] c,
    input logic [FADE_W-1:0] l
  );
    logic [11:0] p;
    p = 12'(c) * (12'(l) + 12'd1);
    return 8'(p >> 4);
  endfunction

endpackage

// File: rtl/dkong3_vmix_fade.sv
// dkong3_vmix_fade: vblank-paced brightness fade.
// Level steps once every FADE_FRAMES vblank rises.
module dkong3_vmix_fade #(
  parameter int FADE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblank,
  input  logic       req,
  input  logic       dir,
  output logic [3:0] level,
  output logic       busy
);
  import dkong3_vmix_pkg::*;

  localparam logic [7:0] CNT_LAST = 8'(FADE_FRAMES - 1);

  fade_state_t state, state_nx;
  logic [3:0] lvl_nx;
  logic [7:0] cnt, cnt_nx;
  logic dir_q, dir_nx;
  logic vb_d;
  logic rise;

  assign rise = vblank & ~vb_d;
  assign busy = (state != FADE_IDLE);

  // State, level, frame counter and edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FADE_IDLE;
      level <= FADE_MAX;
      cnt   <= '0;
      dir_q <= 1'b0;
      vb_d  <= 1'b0;
    end else begin
      state <= state_nx;
      level <= lvl_nx;
      cnt   <= cnt_nx;
      dir_q <= dir_nx;
      vb_d  <= vblank;
    end
  end

  // Next state: start, count frames, step level
  always_comb begin
    state_nx = state;
    lvl_nx   = level;
    cnt_nx   = cnt;
    dir_nx   = dir_q;
    unique case (state)
      FADE_IDLE: begin
        cnt_nx = '0;
        if (req && (dir ? level != FADE_MIN
                        : level != FADE_MAX)) begin
          state_nx = FADE_WAIT;
          dir_nx   = dir;
        end
      end
      FADE_WAIT: begin
        if (rise) begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            state_nx = FADE_STEP;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
      end
      FADE_STEP: begin
        lvl_nx = dir_q ? level - 4'd1 : level + 4'd1;
        if (lvl_nx == (dir_q ? FADE_MIN : FADE_MAX))
          state_nx = FADE_IDLE;
        else
          state_nx = FADE_WAIT;
      end
      default: state_nx = FADE_IDLE;
    endcase
  end

endmodule

// File: rtl/dkong3_vmix.sv
// dkong3_vmix: layer priority mixer, palette RAM, fade.
// Four-stage pipeline advanced only by I_PIX_CE.
module dkong3_vmix #(
  parameter int          NUM_LAYERS  = 2,
  parameter int          COL_W       = 4,
  parameter int          PIX_W       = 2,
  parameter int          RGB_W       = 4,
  parameter int          SEL_W       = 2,
  parameter logic [17:0] DL_BASE     = 18'h3C000,
  parameter int          FADE_FRAMES = 4
) (
  input  logic I_CLK_24M,
  input  logic I_RESETn,
  input  logic I_PIX_CE,
  input  logic [NUM_LAYERS*(COL_W+PIX_W)-1:0] I_LAYER_D,
  input  logic [NUM_LAYERS-1:0] I_LAYER_EN,
  input  logic I_CBLANKn,
  input  logic I_VBLANK,
  input  logic [SEL_W-1:0] I_PAL_SEL,
  input  logic [17:0] I_DLADDR,
  input  logic [7:0] I_DLDATA,
  input  logic I_DLWR,
  input  logic I_FADE_REQ,
  input  logic I_FADE_DIR,
  output logic [RGB_W-1:0] O_R,
  output logic [RGB_W-1:0] O_G,
  output logic [RGB_W-1:0] O_B,
  output logic O_BLANKn,
  output logic O_FADE_BUSY
);
  import dkong3_vmix_pkg::*;

  localparam int LW     = COL_W + PIX_W;
  localparam int DW     = NUM_LAYERS * LW;
  localparam int LIDX_W = $clog2(NUM_LAYERS);
  localparam int AW     = SEL_W + LIDX_W + LW;
  localparam int DEPTH  = 1 << AW;

  logic [DW-1:0] s1_d;
  logic [NUM_LAYERS-1:0] s1_en;
  logic s1_blank;
  logic [SEL_W-1:0] s1_sel;

  logic [LIDX_W-1:0] win_idx;
  logic [COL_W-1:0] win_col;
  logic [PIX_W-1:0] win_pix;
  logic [LW-1:0] lyr;

  logic [AW-1:0] s2_addr;
  logic s2_blank;
  logic [RGB_W-1:0] s3_r, s3_g, s3_b;
  logic s3_blank;

  logic [RGB_W-1:0] mem_r [DEPTH];
  logic [RGB_W-1:0] mem_g [DEPTH];
  logic [RGB_W-1:0] mem_b [DEPTH];

  logic [18:0] dl_off;
  logic dl_hit;
  logic [AW-1:0] dl_ent;
  logic [1:0] dl_lane;
  logic [3:0] fade_lvl;
  logic unused_dl;

  assign dl_off  = {1'b0, I_DLADDR} - {1'b0, DL_BASE};
  assign dl_hit  = I_DLWR && !dl_off[18]
                && ((dl_off[17:0] >> (AW + 2)) == '0);
  assign dl_ent  = dl_off[AW+1:2];
  assign dl_lane = dl_off[1:0];
  assign unused_dl = ^{I_DLDATA, dl_off};

  // S1: capture layer data and controls
  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      s1_d     <= '0;
      s1_en    <= '0;
      s1_blank <= 1'b0;
      s1_sel   <= '0;
    end else if (I_PIX_CE) begin
      s1_d     <= I_LAYER_D;
      s1_en    <= I_LAYER_EN;
      s1_blank <= I_CBLANKn;
      s1_sel   <= I_PAL_SEL;
    end
  end

  // Highest enabled layer with non-zero pixel wins
  always_comb begin
    win_idx = '0;
    win_col = s1_d[PIX_W +: COL_W];
    win_pix = '0;
    lyr     = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      lyr = s1_d[k*LW +: LW];
      if (s1_en[k] && lyr[PIX_W-1:0] != '0) begin
        win_idx = LIDX_W'(k);
        win_col = lyr[LW-1:PIX_W];
        win_pix = lyr[PIX_W-1:0];
      end
    end
  end

  // S2: register palette address
  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      s2_addr  <= '0;
      s2_blank <= 1'b0;
    end else if (I_PIX_CE) begin
      s2_addr  <= {s1_sel, win_idx, win_col, win_pix};
      s2_blank <= s1_blank;
    end
  end

  // Palette download, one lane per byte address
  always_ff @(posedge I_CLK_24M) begin
    if (dl_hit) begin
      case (dl_lane)
        LANE_R:  mem_r[dl_ent] <= I_DLDATA[RGB_W-1:0];
        LANE_G:  mem_g[dl_ent] <= I_DLDATA[RGB_W-1:0];
        LANE_B:  mem_b[dl_ent] <= I_DLDATA[RGB_W-1:0];
        default: ;
      endcase
    end
  end

  // S3: synchronous palette read, old data on collision
  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      s3_r     <= '0;
      s3_g     <= '0;
      s3_b     <= '0;
      s3_blank <= 1'b0;
    end else if (I_PIX_CE) begin
      s3_r     <= mem_r[s2_addr];
      s3_g     <= mem_g[s2_addr];
      s3_b     <= mem_b[s2_addr];
      s3_blank <= s2_blank;
    end
  end

  // S4: fade scaling and blank gating
  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      O_R      <= '0;
      O_G      <= '0;
      O_B      <= '0;
      O_BLANKn <= 1'b0;
    end else if (I_PIX_CE) begin
      O_BLANKn <= s3_blank;
      O_R <= s3_blank
           ? RGB_W'(fade_scale(8'(s3_r), fade_lvl)) : '0;
      O_G <= s3_blank
           ? RGB_W'(fade_scale(8'(s3_g), fade_lvl)) : '0;
      O_B <= s3_blank
           ? RGB_W'(fade_scale(8'(s3_b), fade_lvl)) : '0;
    end
  end

  dkong3_vmix_fade #(
    .FADE_FRAMES(FADE_FRAMES)
  ) u_fade (
    .clk   (I_CLK_24M),
    .rst_n (I_RESETn),
    .vblank(I_VBLANK),
    .req   (I_FADE_REQ),
    .dir   (I_FADE_DIR),
    .level (fade_lvl),
    .busy  (O_FADE_BUSY)
  );

endmodule

// File: tb/tb_dkong3_vmix.sv
// tb_dkong3_vmix: random + directed bench for dkong3_vmix.
// Behavioural palette/fade model, per-cycle compare.
module tb_dkong3_vmix;

  localparam int BASE = 'h3C000;

  logic        clk = 0;
  logic        I_RESETn = 0;
  logic        I_PIX_CE = 0;
  logic [11:0] I_LAYER_D = '0;
  logic [1:0]  I_LAYER_EN = '0;
  logic        I_CBLANKn = 0;
  logic        I_VBLANK = 0;
  logic [1:0]  I_PAL_SEL = '0;
  logic [17:0] I_DLADDR = '0;
  logic [7:0]  I_DLDATA = '0;
  logic        I_DLWR = 0;
  logic        I_FADE_REQ = 0;
  logic        I_FADE_DIR = 0;
  logic [3:0]  O_R, O_G, O_B;
  logic        O_BLANKn, O_FADE_BUSY;

  dkong3_vmix #(.FADE_FRAMES(1)) dut (
    .I_CLK_24M(clk), .I_RESETn(I_RESETn),
    .I_PIX_CE(I_PIX_CE), .I_LAYER_D(I_LAYER_D),
    .I_LAYER_EN(I_LAYER_EN), .I_CBLANKn(I_CBLANKn),
    .I_VBLANK(I_VBLANK), .I_PAL_SEL(I_PAL_SEL),
    .I_DLADDR(I_DLADDR), .I_DLDATA(I_DLDATA),
    .I_DLWR(I_DLWR), .I_FADE_REQ(I_FADE_REQ),
    .I_FADE_DIR(I_FADE_DIR), .O_R(O_R), .O_G(O_G),
    .O_B(O_B), .O_BLANKn(O_BLANKn),
    .O_FADE_BUSY(O_FADE_BUSY)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; bit blank; } ent_t;

  int   errors = 0;
  int   checks = 0;
  int   pal [3][512];
  ent_t q[$];
  int   h_rgb [3];
  bit   h_blank;
  int   er, eg, eb;
  bit   eblk;
  int   L_m, cnt_m;
  bit   busy_m, dir_m;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int exp_addr(input logic [11:0] d,
                                  input logic [1:0] en,
                                  input int sel);
    int w, col, pix;
    w = -1; col = 0; pix = 0;
    for (int k = 0; k < 2; k++) begin
      int c, p;
      c = (int'(d) >> (6 * k + 2)) % 16;
      p = (int'(d) >> (6 * k)) % 4;
      if (en[k] && p != 0) begin
        w = k; col = c; pix = p;
      end
    end
    if (w < 0) begin
      w = 0; col = (int'(d) >> 2) % 16; pix = 0;
    end
    return sel * 128 + w * 64 + col * 4 + pix;
  endfunction

  function automatic int scale(input int c, input int l);
    return (c * (l + 1)) / 16;
  endfunction

  task automatic mdl_reset();
    q.delete();
    q.push_back('{addr: 0, blank: 0});
    q.push_back('{addr: 0, blank: 0});
    h_rgb = '{0, 0, 0};
    h_blank = 0;
    er = 0; eg = 0; eb = 0; eblk = 0;
    L_m = 15; cnt_m = 0; busy_m = 0; dir_m = 0;
  endtask

  task automatic pal_upd(input int a, input int d);
    int off;
    off = a - BASE;
    if (off >= 0 && off < 2048 && off % 4 != 3)
      pal[off % 4][off / 4] = d % 16;
  endtask

  // Per-cycle compare against the model
  always begin
    @(posedge clk);
    if (I_RESETn) begin
      if (I_PIX_CE) begin
        ent_t e;
        eblk = h_blank;
        er = eblk ? scale(h_rgb[0], L_m) : 0;
        eg = eblk ? scale(h_rgb[1], L_m) : 0;
        eb = eblk ? scale(h_rgb[2], L_m) : 0;
        e = q.pop_front();
        h_rgb[0] = pal[0][e.addr];
        h_rgb[1] = pal[1][e.addr];
        h_rgb[2] = pal[2][e.addr];
        h_blank = e.blank;
        q.push_back('{addr: exp_addr(I_LAYER_D, I_LAYER_EN,
                                     int'(I_PAL_SEL)),
                      blank: I_CBLANKn});
      end
      #1;
      if (I_RESETn) begin
        chk("pix_r", O_R, er);
        chk("pix_g", O_G, eg);
        chk("pix_b", O_B, eb);
        chk("blankn", O_BLANKn, eblk);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic dl(input int a, input int d);
    I_DLADDR = 18'(a); I_DLDATA = 8'(d); I_DLWR = 1;
    tick();
    pal_upd(a, d);
    I_DLWR = 0;
  endtask

  task automatic pix(input logic [11:0] d,
                     input logic [1:0] en, input bit cb,
                     input int sel, input int gap,
                     input bit wr, input int wa, input int wd);
    I_LAYER_D = d; I_LAYER_EN = en; I_CBLANKn = cb;
    I_PAL_SEL = 2'(sel);
    I_PIX_CE = 1;
    I_DLWR = wr; I_DLADDR = 18'(wa); I_DLDATA = 8'(wd);
    tick();
    if (wr) pal_upd(wa, wd);
    I_PIX_CE = 0; I_DLWR = 0;
    repeat (gap) tick();
  endtask

  task automatic push4(input logic [11:0] d,
                       input logic [1:0] en, input int sel);
    for (int i = 0; i < 4; i++)
      pix(d, en, 1'b1, sel, 1, 1'b0, 0, 0);
  endtask

  task automatic run4(input logic [11:0] d,
                      input logic [1:0] en, input int sel,
                      input int r, input int g, input int b,
                      input string nm);
    for (int i = 0; i < 3; i++)
      pix(12'h000, 2'b00, 1'b0, 0, 1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      pix(d, en, 1'b1, sel, 1, 1'b0, 0, 0);
      if (i == 2) chk({nm, "_early"}, O_BLANKn, 0);
    end
    chk({nm, "_r"}, O_R, r);
    chk({nm, "_g"}, O_G, g);
    chk({nm, "_b"}, O_B, b);
  endtask

  task automatic fade_req(input bit dir);
    I_FADE_DIR = dir; I_FADE_REQ = 1;
    tick();
    I_FADE_REQ = 0;
    if (!busy_m && (dir ? L_m != 0 : L_m != 15)) begin
      busy_m = 1; dir_m = dir; cnt_m = 0;
    end
    chk("busy_req", O_FADE_BUSY, busy_m);
  endtask

  task automatic vbl();
    I_VBLANK = 1; repeat (3) tick();
    I_VBLANK = 0; repeat (3) tick();
    if (busy_m) begin
      cnt_m++;
      if (cnt_m == 1) begin
        cnt_m = 0;
        L_m = dir_m ? L_m - 1 : L_m + 1;
        if (L_m == (dir_m ? 0 : 15)) busy_m = 0;
      end
    end
    chk("busy_vbl", O_FADE_BUSY, busy_m);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    I_RESETn = 0;
    #1;
    chk("rst_r", O_R, 0);
    chk("rst_g", O_G, 0);
    chk("rst_b", O_B, 0);
    chk("rst_blankn", O_BLANKn, 0);
    chk("rst_busy", O_FADE_BUSY, 0);
    mdl_reset();
    I_FADE_REQ = 0; I_VBLANK = 0; I_PIX_CE = 0;
    repeat (2) @(posedge clk);
    #3;
    I_RESETn = 1;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    logic [11:0] da;
    bit cbv [7];
    mdl_reset();
    for (int l = 0; l < 3; l++)
      for (int e = 0; e < 512; e++) pal[l][e] = 0;
    do_reset();

    // full palette load plus ignored lane-3 writes
    for (int e = 0; e < 512; e++) begin
      for (int l = 0; l < 3; l++)
        dl(BASE + e * 4 + l, int'($urandom_range(0, 255)));
      if (e % 64 == 0)
        dl(BASE + e * 4 + 3, int'($urandom_range(0, 255)));
    end

    // directed priority / address cases
    dl(BASE + 'h358, 'hA); dl(BASE + 'h359, 'h5);
    dl(BASE + 'h35A, 'hF);
    dl(BASE + 'h234, 1); dl(BASE + 'h235, 2);
    dl(BASE + 'h236, 3);
    dl(BASE + 'h230, 7); dl(BASE + 'h231, 8);
    dl(BASE + 'h232, 9);
    run4(12'h58D, 2'b11, 1, 'hA, 'h5, 'hF, "both");
    run4(12'h50D, 2'b11, 1, 1, 2, 3, "l1pix0");
    run4(12'h58D, 2'b01, 1, 1, 2, 3, "l1dis");
    run4(12'h58D, 2'b10, 1, 'hA, 'h5, 'hF, "l1only");
    run4(12'h58D, 2'b00, 1, 7, 8, 9, "none_en");
    run4(12'h50C, 2'b11, 1, 7, 8, 9, "none_pix");

    // out-of-window writes must not land
    dl(BASE, 1); dl(BASE + 1, 1); dl(BASE + 2, 1);
    dl(BASE + 'h7FC, 2); dl(BASE + 'h7FD, 2);
    dl(BASE + 'h7FE, 2);
    dl(BASE + 'h800, 'hFF);
    dl(BASE - 4, 'hFF);
    run4(12'h000, 2'b00, 0, 1, 1, 1, "win_hi");
    run4(12'hFFF, 2'b10, 3, 2, 2, 2, "win_lo");

    // blank pulse through the pipe
    cbv = '{1, 1, 0, 1, 1, 1, 1};
    for (int i = 0; i < 7; i++) begin
      pix(12'h58D, 2'b11, cbv[i], 1, 1, 1'b0, 0, 0);
      if (i == 4) chk("cb_before", O_BLANKn, 1);
      if (i == 5) begin
        chk("cb_low", O_BLANKn, 0);
        chk("cb_rgb0", O_R, 0);
      end
      if (i == 6) chk("cb_after", O_BLANKn, 1);
    end

    // random stream with occasional concurrent writes
    for (int i = 0; i < 400; i++) begin
      bit wr;
      int wa;
      wr = ($urandom_range(0, 9) == 0);
      wa = BASE - 8 + int'($urandom_range(0, 2100));
      if ($urandom_range(0, 3) == 0)
        wa = BASE + exp_addr(I_LAYER_D, I_LAYER_EN,
                             int'(I_PAL_SEL)) * 4
           + int'($urandom_range(0, 3));
      da = 12'($urandom);
      pix(da, 2'($urandom_range(0, 3)),
          $urandom_range(0, 7) != 0,
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)),
          wr, wa, int'($urandom_range(0, 255)));
    end

    // fade out, second request mid-fade ignored
    dl(BASE + 'h358, 'hF);
    fade_req(1);
    chk("fade_busy_on", O_FADE_BUSY, 1);
    for (int i = 1; i <= 15; i++) begin
      vbl();
      if (i == 5) fade_req(0);
      push4(12'h58D, 2'b11, 1);
      if (L_m == 7) chk("fade_l7_r", O_R, 7);
      if (i == 14) chk("fade_busy_14", O_FADE_BUSY, 1);
    end
    chk("fade_done", O_FADE_BUSY, 0);
    chk("fade_l0_r", O_R, 0);
    fade_req(1);
    chk("fade_at_tgt", O_FADE_BUSY, 0);

    // fade in partway, then reset mid-fade
    fade_req(0);
    for (int i = 0; i < 8; i++) vbl();
    push4(12'h58D, 2'b11, 1);
    chk("fade_l8_r", O_R, 8);
    chk("fade_in_busy", O_FADE_BUSY, 1);
    do_reset();
    push4(12'h58D, 2'b11, 1);
    chk("post_rst_r", O_R, 'hF);
    fade_req(0);
    chk("post_rst_idle", O_FADE_BUSY, 0);

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
